// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester-side request/ready bundle for ram_arbiter
interface ram_arbiter_if;
    logic        req;
    logic [3:0]  write_strobe;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        ready;
    logic [31:0] read_data;
    logic        error;

    modport master (
        output req, write_strobe, address, write_data,
        input  ready, read_data, error
    );

    modport slave (
        input  req, write_strobe, address, write_data,
        output ready, read_data, error
    );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port arbiter/sequencer for a single-port word RAM
// Sub-word stores become read-modify-write so the RAM only sees full-word writes.
module ram_arbiter #(
    parameter int WORDS = 4096,
    parameter bit FAIR  = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    ram_arbiter_if.slave p0,
    ram_arbiter_if.slave p1,
    output logic [3:0]   ram_control,
    output logic [31:0]  ram_address,
    output logic [31:0]  ram_write_data,
    input  logic [31:0]  ram_read_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESPOND} state_t;

    state_t      r_state;
    logic        r_last_grant;
    logic        r_port;
    logic        r_err;
    logic [3:0]  r_strobe;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_ram_control;
    logic [31:0] r_ram_address;
    logic [31:0] r_ram_write_data;
    logic        r_p0_ready;
    logic        r_p1_ready;
    logic        r_p0_error;
    logic        r_p1_error;
    logic [31:0] r_p0_read_data;
    logic [31:0] r_p1_read_data;

    logic        w_winner;
    logic [3:0]  w_strobe;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_err;
    logic        w_partial;
    logic [31:0] w_merged;
    logic [31:0] w_resp_data;

    always_comb begin
        w_winner = p1.req;
        if (p0.req && p1.req) begin
            w_winner = FAIR ? ~r_last_grant : 1'b0;
        end
    end

    assign w_strobe = w_winner ? p1.write_strobe : p0.write_strobe;
    assign w_addr   = w_winner ? p1.address      : p0.address;
    assign w_wdata  = w_winner ? p1.write_data   : p0.write_data;
    assign w_err    = (w_addr[1:0] != 2'b00) || ({2'b00, w_addr[31:2]} >= 32'(WORDS));

    assign w_partial   = !r_err && (r_strobe != 4'h0) && (r_strobe != 4'hF);
    assign w_resp_data = (r_state == ACCESS && !r_err && r_strobe == 4'h0) ? ram_read_data : 32'h0;

    always_comb begin
        w_merged = ram_read_data;
        for (int i = 0; i < 4; i++) begin
            if (r_strobe[i]) begin
                w_merged[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_last_grant     <= 1'b1;
            r_port           <= 1'b0;
            r_err            <= 1'b0;
            r_strobe         <= 4'h0;
            r_addr           <= 32'h0;
            r_wdata          <= 32'h0;
            r_ram_control    <= 4'h0;
            r_ram_address    <= 32'h0;
            r_ram_write_data <= 32'h0;
            r_p0_ready       <= 1'b0;
            r_p1_ready       <= 1'b0;
            r_p0_error       <= 1'b0;
            r_p1_error       <= 1'b0;
            r_p0_read_data   <= 32'h0;
            r_p1_read_data   <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (p0.req || p1.req) begin
                        r_port       <= w_winner;
                        r_last_grant <= w_winner;
                        r_strobe     <= w_strobe;
                        r_addr       <= w_addr;
                        r_wdata      <= w_wdata;
                        r_err        <= w_err;
                        r_state      <= ACCESS;
                        // Errored requests still spend the ACCESS slot, with the RAM bus left quiet.
                        if (!w_err) begin
                            r_ram_address <= w_addr;
                            if (w_strobe == 4'hF) begin
                                r_ram_control    <= 4'hF;
                                r_ram_write_data <= w_wdata;
                            end
                        end
                    end
                end
                ACCESS, MERGE: begin
                    if (r_state == ACCESS && w_partial) begin
                        r_ram_control    <= 4'hF;
                        r_ram_write_data <= w_merged;
                        r_state          <= MERGE;
                    end else begin
                        r_ram_control    <= 4'h0;
                        r_ram_address    <= 32'h0;
                        r_ram_write_data <= 32'h0;
                        r_p0_ready       <= ~r_port;
                        r_p1_ready       <= r_port;
                        r_p0_error       <= ~r_port & r_err;
                        r_p1_error       <= r_port & r_err;
                        r_p0_read_data   <= r_port ? 32'h0 : w_resp_data;
                        r_p1_read_data   <= r_port ? w_resp_data : 32'h0;
                        r_state          <= RESPOND;
                    end
                end
                RESPOND: begin
                    r_p0_ready     <= 1'b0;
                    r_p1_ready     <= 1'b0;
                    r_p0_error     <= 1'b0;
                    r_p1_error     <= 1'b0;
                    r_p0_read_data <= 32'h0;
                    r_p1_read_data <= 32'h0;
                    r_state        <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign p0.ready       = r_p0_ready;
    assign p0.error       = r_p0_error;
    assign p0.read_data   = r_p0_read_data;
    assign p1.ready       = r_p1_ready;
    assign p1.error       = r_p1_error;
    assign p1.read_data   = r_p1_read_data;
    assign ram_control    = r_ram_control;
    assign ram_address    = r_ram_address;
    assign ram_write_data = r_ram_write_data;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized bench for ram_arbiter against a transaction-level model
module tb_ram_arbiter;
    localparam int          WORDS   = 4096;
    localparam logic [31:0] FP_WORD = 32'h5A5A_0001;

    typedef struct packed {
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic preload = 1'b0;
    always #5 clock = ~clock;

    ram_arbiter_if if0 ();
    ram_arbiter_if if1 ();
    ram_arbiter_if fp0 ();
    ram_arbiter_if fp1 ();

    logic [3:0]  ram_control, fp_ram_control;
    logic [31:0] ram_address, ram_write_data, ram_read_data;
    logic [31:0] fp_ram_address, fp_ram_write_data;

    logic        s_req  [2];
    logic [3:0]  s_strb [2];
    logic [31:0] s_addr [2];
    logic [31:0] s_data [2];

    assign if0.req = s_req[0];  assign if0.write_strobe = s_strb[0];
    assign if0.address = s_addr[0];  assign if0.write_data = s_data[0];
    assign if1.req = s_req[1];  assign if1.write_strobe = s_strb[1];
    assign if1.address = s_addr[1];  assign if1.write_data = s_data[1];

    ram_arbiter #(.WORDS(WORDS), .FAIR(1'b1)) dut (
        .clock(clock), .reset(reset), .p0(if0), .p1(if1),
        .ram_control(ram_control), .ram_address(ram_address),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
    );

    ram_arbiter #(.WORDS(WORDS), .FAIR(1'b0)) dut_fp (
        .clock(clock), .reset(reset), .p0(fp0), .p1(fp1),
        .ram_control(fp_ram_control), .ram_address(fp_ram_address),
        .ram_write_data(fp_ram_write_data), .ram_read_data(FP_WORD)
    );

    logic [31:0] mem_ram   [0:WORDS-1];
    logic [31:0] model_mem [0:WORDS-1];

    assign ram_read_data = mem_ram[ram_address[13:2]];
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < WORDS; i++) mem_ram[i] <= model_mem[i];
        end else if (ram_control == 4'hF) begin
            mem_ram[ram_address[13:2]] <= ram_write_data;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    txn_t q0[$];
    txn_t q1[$];
    txn_t cur[2];
    bit   pend[2];
    bit   granted[2];
    int   obs_log[$];

    int          cyc, free_at, exp_ready_cyc, exp_port, exp_wr_cyc;
    bit          last_g, exp_err;
    logic [31:0] exp_rdata, exp_wr_addr, exp_wr_data;

    function automatic void push(input int p, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t = '{strb: s, addr: a, data: d};
        if (p == 0) q0.push_back(t);
        else q1.push_back(t);
    endfunction

    task automatic pop(input int p, output bit ok, output txn_t t);
        t  = '0;
        ok = 1'b0;
        if (p == 0 && q0.size() > 0) begin ok = 1'b1; t = q0.pop_front(); end
        if (p == 1 && q1.size() > 0) begin ok = 1'b1; t = q1.pop_front(); end
    endtask

    task automatic rand_txn(input int p);
        int          r;
        logic [3:0]  s;
        logic [31:0] a;
        r = $urandom_range(0, 99);
        s = (r < 40) ? 4'h0 : (r < 65) ? 4'hF : 4'($urandom_range(1, 14));
        a = 32'($urandom_range(0, 31)) << 2;
        r = $urandom_range(0, 99);
        if (r < 10) a = a | 32'($urandom_range(1, 3));
        else if (r < 20) a = 32'h4000 + (32'($urandom_range(0, 1023)) << 2);
        push(p, s, a, $urandom);
    endtask

    task automatic step();
        bit          rdy, ok;
        int          w, lat;
        txn_t        t;
        logic [31:0] nw;
        logic [11:0] idx;
        rdy = (cyc == exp_ready_cyc);
        chk("p0_resp", {if0.ready, if0.error, if0.read_data},
            (rdy && exp_port == 0) ? {1'b1, exp_err, exp_rdata} : 34'h0);
        chk("p1_resp", {if1.ready, if1.error, if1.read_data},
            (rdy && exp_port == 1) ? {1'b1, exp_err, exp_rdata} : 34'h0);
        if (cyc == exp_wr_cyc)
            chk("ram_write", {ram_control, ram_address, ram_write_data}, {4'hF, exp_wr_addr, exp_wr_data});
        else
            chk("ram_ctrl_quiet", ram_control, 4'h0);
        if (if0.ready) obs_log.push_back(0);
        if (if1.ready) obs_log.push_back(1);

        for (int p = 0; p < 2; p++) begin
            if (rdy && exp_port == p) begin pend[p] = 0; granted[p] = 0; end
            if (!pend[p]) begin
                pop(p, ok, t);
                if (ok) begin pend[p] = 1; cur[p] = t; end
            end
            if (granted[p]) begin
                s_req[p] = 1'($urandom); s_strb[p] = 4'($urandom);
                s_addr[p] = $urandom;    s_data[p] = $urandom;
            end else if (pend[p]) begin
                s_req[p] = 1'b1; s_strb[p] = cur[p].strb;
                s_addr[p] = cur[p].addr; s_data[p] = cur[p].data;
            end else begin
                s_req[p] = 1'b0; s_strb[p] = 4'($urandom);
                s_addr[p] = $urandom;    s_data[p] = $urandom;
            end
        end

        if (cyc >= free_at && (pend[0] || pend[1])) begin
            w = (pend[0] && pend[1]) ? (last_g ? 0 : 1) : (pend[1] ? 1 : 0);
            last_g = (w == 1);
            granted[w] = 1;
            t = cur[w];
            idx = t.addr[13:2];
            exp_err = (t.addr[1:0] != 2'b00) || ({2'b00, t.addr[31:2]} >= 32'(WORDS));
            lat = 2; exp_rdata = 32'h0; exp_wr_cyc = -1;
            if (!exp_err) begin
                if (t.strb == 4'h0) exp_rdata = model_mem[idx];
                else begin
                    nw = model_mem[idx];
                    for (int b = 0; b < 4; b++) if (t.strb[b]) nw[8*b +: 8] = t.data[8*b +: 8];
                    lat = (t.strb == 4'hF) ? 2 : 3;
                    exp_wr_cyc = cyc + lat - 1;
                    exp_wr_addr = t.addr;
                    exp_wr_data = nw;
                    model_mem[idx] = nw;
                end
            end
            exp_ready_cyc = cyc + lat;
            exp_port = w;
            free_at = cyc + lat + 1;
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic run_phase(input int bound);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < bound) begin
            step();
            n++;
            done = (q0.size() == 0) && (q1.size() == 0) && !pend[0] && !pend[1] && (cyc >= free_at);
        end
        chk("phase_done", done, 1'b1);
    endtask

    initial begin
        int         c0, c1;
        logic [7:0] order;
        for (int p = 0; p < 2; p++) begin
            s_req[p] = 1'b0; s_strb[p] = 4'h0; s_addr[p] = 32'h0; s_data[p] = 32'h0;
            pend[p] = 1'b0; granted[p] = 1'b0;
        end
        fp0.req = 1'b0; fp0.write_strobe = 4'h0; fp0.address = 32'h0; fp0.write_data = 32'h0;
        fp1.req = 1'b0; fp1.write_strobe = 4'h0; fp1.address = 32'h4; fp1.write_data = 32'h0;
        for (int i = 0; i < WORDS; i++) model_mem[i] = $urandom;
        model_mem[16] = 32'h1122_3344;

        #1 reset = 1'b0;
        preload = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_ports", {if0.ready, if0.error, if0.read_data, if1.ready, if1.error, if1.read_data}, 68'h0);
        chk("reset_ram", {ram_control, ram_address, ram_write_data}, 68'h0);
        preload = 1'b0;
        reset = 1'b1;
        cyc = 0; free_at = 0; exp_ready_cyc = -1; exp_wr_cyc = -1; exp_port = 0; last_g = 1'b1;

        push(0, 4'h0, 32'h40, 32'h0);                 run_phase(20);
        push(1, 4'b0010, 32'h40, 32'hAABB_CCDD);      run_phase(20);
        push(0, 4'h0, 32'h40, 32'h0);                 run_phase(20);
        chk("mem_0x40", mem_ram[16], 32'h1122_CC44);
        push(0, 4'hF, 32'h80, 32'hDEAD_BEEF);
        push(0, 4'h0, 32'h80, 32'h0);                 run_phase(20);
        chk("mem_0x80", mem_ram[32], 32'hDEAD_BEEF);
        push(1, 4'h0, 32'h42, 32'h0);
        push(1, 4'hF, 32'h4000, 32'h1234_5678);       run_phase(20);

        obs_log.delete();
        for (int i = 0; i < 2; i++) begin
            push(0, 4'h0, 32'h10, 32'h0);
            push(1, 4'h0, 32'h14, 32'h0);
        end
        run_phase(40);
        order = 8'h0;
        foreach (obs_log[i]) order = {order[5:0], 2'(obs_log[i])};
        chk("fair_order", {32'(obs_log.size()), order}, {32'd4, 8'b00_01_00_01});

        for (int i = 0; i < 150; i++) begin rand_txn(0); rand_txn(1); end
        run_phase(2000);

        fp0.req = 1'b1;
        fp1.req = 1'b1;
        c0 = 0; c1 = 0;
        repeat (12) begin
            @(negedge clock);
            if (fp0.ready) begin c0++; chk("fp_p0_data", fp0.read_data, FP_WORD); end
            if (fp1.ready) c1++;
            chk("fp_ram_ctrl", fp_ram_control, 4'h0);
        end
        chk("fp_p0_grants", c0, 4);
        chk("fp_p1_grants", c1, 0);
        fp0.req = 1'b0;
        fp1.req = 1'b0;

        model_mem[16] = 32'h1122_3344;
        preload = 1'b1;
        @(negedge clock);
        preload = 1'b0;
        s_req[1] = 1'b1; s_strb[1] = 4'b0010; s_addr[1] = 32'h40; s_data[1] = 32'hAABB_CCDD;
        @(negedge clock);
        @(negedge clock);
        chk("merge_write", {ram_control, ram_address, ram_write_data}, {4'hF, 32'h40, 32'h1122_CC44});
        s_req[0] = 1'b1; s_strb[0] = 4'h0; s_addr[0] = 32'h40; s_data[0] = 32'h0;
        #1 reset = 1'b0;
        #1;
        chk("rst_ram_out", {ram_control, ram_address, ram_write_data}, 68'h0);
        chk("rst_port_out", {if0.ready, if0.error, if0.read_data, if1.ready, if1.error, if1.read_data}, 68'h0);
        @(negedge clock);
        chk("merge_aborted", mem_ram[16], 32'h1122_3344);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("post_rst_p0", {if0.ready, if0.error, if0.read_data}, {1'b1, 1'b0, 32'h1122_3344});
        chk("post_rst_p1", {if1.ready, if1.error, if1.read_data}, 34'h0);
        s_req[0] = 1'b0;
        s_req[1] = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
